// File: rtl/ysyx_22050078_mem_arbiter_pkg.sv
// ysyx_22050078_mem_arbiter_pkg: state/owner encodings and mask width helper for the memory arbiter
package ysyx_22050078_mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;
    function automatic int mask_width(input int data_width);
        return data_width / 8;
    endfunction
endpackage

// File: rtl/ysyx_22050078_mem_arbiter_if.sv
// ysyx_22050078_mem_arbiter_if: IFU, LSU and memory-side handshake bundle for the arbiter
interface ysyx_22050078_mem_arbiter_if
    import ysyx_22050078_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    localparam int MW = mask_width(DATA_WIDTH);
    logic                  if_req_valid, if_req_ready, if_rsp_valid;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata, ls_rdata;
    logic [MW-1:0]         ls_wmask;
    logic                  mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0]         mem_wmask;
    modport slave (
        input  if_req_valid, if_addr, ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
               mem_req_ready, mem_rsp_valid, mem_rdata,
        output if_req_ready, if_rsp_valid, if_rdata, ls_req_ready, ls_rsp_valid, ls_rdata,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
    modport master (
        output if_req_valid, if_addr, ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
               mem_req_ready, mem_rsp_valid, mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rdata, ls_req_ready, ls_rsp_valid, ls_rdata,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_22050078_rr_arb2.sv
// ysyx_22050078_rr_arb2: two-way round-robin grant, bit 0 = IF, bit 1 = LS, one-hot output
module ysyx_22050078_rr_arb2
    import ysyx_22050078_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    // On a tie the side that did not win last time takes the grant
    assign grant[1] = req[1] & (~req[0] | last == OWN_IF);
    assign grant[0] = req[0] & ~grant[1];
endmodule

// File: rtl/ysyx_22050078_mem_arbiter.sv
// ysyx_22050078_mem_arbiter: shares one memory port between IFU and LSU, one transaction in flight
module ysyx_22050078_mem_arbiter
    import ysyx_22050078_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    ysyx_22050078_mem_arbiter_if.slave        bus,
    output logic                              busy,
    output logic                              err
);
    localparam int MW = mask_width(DATA_WIDTH);
    state_t                state, state_nxt;
    logic                  owner, last_grant;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MW-1:0]         wmask_q;
    logic [1:0]            grant;
    logic                  accept, rsp_fire;

    ysyx_22050078_rr_arb2 u_rr (
        .req   ({bus.ls_req_valid, bus.if_req_valid}),
        .last  (last_grant),
        .grant (grant)
    );

    // Readies are gated by rst_n so nothing is accepted while reset is asserted
    assign accept   = state == IDLE && rst_n && |grant;
    assign rsp_fire = state == RSP && bus.mem_rsp_valid;

    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = REQ;
        else if (state == REQ && bus.mem_req_ready) state_nxt = RSP;
        else if (rsp_fire) state_nxt = IDLE;
        bus.if_req_ready  = accept & grant[0];
        bus.ls_req_ready  = accept & grant[1];
        bus.if_rsp_valid  = rsp_fire & owner == OWN_IF;
        bus.ls_rsp_valid  = rsp_fire & owner == OWN_LS;
        bus.if_rdata      = bus.if_rsp_valid ? bus.mem_rdata : '0;
        bus.ls_rdata      = bus.ls_rsp_valid ? bus.mem_rdata : '0;
        bus.mem_req_valid = state == REQ;
        bus.mem_addr      = addr_q;
        bus.mem_wen       = wen_q;
        bus.mem_wdata     = wdata_q;
        bus.mem_wmask     = wmask_q;
        busy              = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_IF;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= grant[1] ? OWN_LS : OWN_IF;
                last_grant <= grant[1] ? OWN_LS : OWN_IF;
                addr_q     <= grant[1] ? bus.ls_addr : bus.if_addr;
                wen_q      <= grant[1] & bus.ls_wen;
                wdata_q    <= grant[1] ? bus.ls_wdata : '0;
                wmask_q    <= grant[1] ? bus.ls_wmask : '0;
            end
            if (bus.mem_rsp_valid && state != RSP) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ysyx_22050078_mem_arbiter.sv
// tb_ysyx_22050078_mem_arbiter: directed and randomized checks of the IF/LS memory arbiter
module tb_ysyx_22050078_mem_arbiter;
    localparam int AW = 64, DW = 64, MW = DW / 8;
    logic clk = 1'b0, rst_n = 1'b0;
    logic busy, err;
    int   vectors = 0, miscompares = 0;

    ysyx_22050078_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    ysyx_22050078_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: who won last tie, and whether a stray response has been seen
    bit model_last, model_err;

    function automatic logic [1:0] predict(input bit iv, input bit lv);
        bit win_ls;
        if (!iv && !lv) return 2'b00;
        win_ls = (iv && lv) ? !model_last : lv;
        model_last = win_ls;
        return win_ls ? 2'b10 : 2'b01;
    endfunction

    logic [1:0]    o_grant;
    logic [AW-1:0] o_addr;
    logic          o_wen, o_if_rsp, o_ls_rsp;
    logic [DW-1:0] o_wdata, o_if_rdata, o_ls_rdata;
    logic [MW-1:0] o_wmask;
    logic [2:0]    o_after;
    bit            o_stable;
    int            o_bad, o_tries;

    task automatic clear_inputs();
        bus.if_req_valid = 0; bus.if_addr = '0;
        bus.ls_req_valid = 0; bus.ls_addr = '0; bus.ls_wen = 0; bus.ls_wdata = '0; bus.ls_wmask = '0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rdata = '0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        clear_inputs();
        model_last = 0;
        model_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.mem_req_ready = 0;
        bus.mem_rsp_valid = 0;
        #1;
        o_after = {bus.if_rsp_valid, bus.ls_rsp_valid, busy};
    endtask

    // Plays requester and memory for one transaction and records what the DUT showed
    task automatic run_txn(input bit iv, input logic [AW-1:0] ia, input bit lv, input logic [AW-1:0] la,
                           input bit lw, input logic [DW-1:0] ld, input logic [MW-1:0] lm,
                           input int rdy_dly, input int rsp_dly, input logic [DW-1:0] rd);
        o_grant = 0; o_bad = 0; o_stable = 1; o_tries = 0;
        o_if_rsp = 0; o_ls_rsp = 0; o_if_rdata = '0; o_ls_rdata = '0;
        while (o_tries < 4 && o_grant == 2'b00) begin
            @(negedge clk);
            bus.if_req_valid = iv; bus.if_addr = ia;
            bus.ls_req_valid = lv; bus.ls_addr = la; bus.ls_wen = lw; bus.ls_wdata = ld; bus.ls_wmask = lm;
            bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rdata = DW'($urandom);
            #1;
            o_grant = {bus.ls_req_ready, bus.if_req_ready};
            o_tries++;
        end
        if (o_grant == 2'b00) return;
        for (int i = 0; i <= rdy_dly; i++) begin
            @(negedge clk);
            if (o_grant[0]) bus.if_req_valid = 0;
            if (o_grant[1]) bus.ls_req_valid = 0;
            bus.mem_req_ready = (i == rdy_dly);
            bus.mem_rdata = DW'($urandom);
            #1;
            if (i == 0) {o_addr, o_wen, o_wdata, o_wmask} = {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
            else if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !== {o_addr, o_wen, o_wdata, o_wmask}) o_stable = 0;
            if (bus.mem_req_valid !== 1'b1 || busy !== 1'b1) o_bad++;
            if ({bus.if_req_ready, bus.ls_req_ready, bus.if_rsp_valid, bus.ls_rsp_valid} !== 4'b0) o_bad++;
            if ({bus.if_rdata, bus.ls_rdata} !== '0) o_bad++;
        end
        for (int j = 1; j <= rsp_dly; j++) begin
            @(negedge clk);
            bus.mem_req_ready = 0;
            bus.mem_rsp_valid = (j == rsp_dly);
            bus.mem_rdata = (j == rsp_dly) ? rd : DW'($urandom);
            #1;
            if (bus.mem_req_valid !== 1'b0 || busy !== 1'b1 || {bus.if_req_ready, bus.ls_req_ready} !== 2'b0) o_bad++;
            if (j < rsp_dly && ({bus.if_rsp_valid, bus.ls_rsp_valid} !== 2'b0 || {bus.if_rdata, bus.ls_rdata} !== '0)) o_bad++;
        end
        {o_if_rsp, o_ls_rsp, o_if_rdata, o_ls_rdata} = {bus.if_rsp_valid, bus.ls_rsp_valid, bus.if_rdata, bus.ls_rdata};
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        bus.if_req_valid = 1; bus.ls_req_valid = 1; bus.mem_rsp_valid = 1;
        @(negedge clk); #1;
        vectors++; if ({bus.if_req_ready, bus.ls_req_ready, bus.mem_req_valid, bus.if_rsp_valid, bus.ls_rsp_valid, busy, err} !== 7'b0) begin
            miscompares++; $display("FAIL reset_ctrl got %b expected 0000000", {bus.if_req_ready, bus.ls_req_ready, bus.mem_req_valid, bus.if_rsp_valid, bus.ls_rsp_valid, busy, err}); end
        vectors++; if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !== '0) begin
            miscompares++; $display("FAIL reset_fields got addr=%h wen=%b wdata=%h wmask=%h expected all 0", bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask); end
        clear_inputs();
        model_last = 0;
        model_err = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_if_read();
        logic [1:0] e = predict(1, 0);
        run_txn(1, 64'h8000_0000, 0, '0, 0, '0, '0, 0, 1, 64'h0010_0073);
        vectors++; if (o_grant !== e) begin miscompares++; $display("FAIL if_grant got %b expected %b", o_grant, e); end
        vectors++; if ({o_addr, o_wen, o_wmask} !== {64'h8000_0000, 1'b0, 8'h00}) begin
            miscompares++; $display("FAIL if_fields got addr=%h wen=%b wmask=%h expected 80000000/0/00", o_addr, o_wen, o_wmask); end
        vectors++; if ({o_if_rsp, o_ls_rsp} !== 2'b10 || o_if_rdata !== 64'h0010_0073 || o_ls_rdata !== '0) begin
            miscompares++; $display("FAIL if_rsp got if=%b ls=%b rdata=%h expected if=1 ls=0 rdata=100073", o_if_rsp, o_ls_rsp, o_if_rdata); end
        vectors++; if (o_bad !== 0) begin miscompares++; $display("FAIL if_wait got %0d bad cycles expected 0", o_bad); end
        idle_cycle();
        vectors++; if (o_after !== 3'b000) begin miscompares++; $display("FAIL if_pulse got rsp/busy %b expected 000", o_after); end
    endtask

    task automatic test_tie();
        logic [1:0] e;
        apply_reset();
        e = predict(1, 1);
        run_txn(1, 64'h100, 1, 64'h200, 0, '0, '0, 0, 1, 64'hAAAA);
        vectors++; if (o_grant !== e || o_addr !== 64'h200) begin miscompares++; $display("FAIL tie1_grant got %b addr=%h expected %b addr=200", o_grant, o_addr, e); end
        vectors++; if ({o_if_rsp, o_ls_rsp} !== 2'b01 || o_ls_rdata !== 64'hAAAA) begin
            miscompares++; $display("FAIL tie1_rsp got if=%b ls=%b rdata=%h expected 0/1/aaaa", o_if_rsp, o_ls_rsp, o_ls_rdata); end
        e = predict(1, 0);
        run_txn(1, 64'h100, 0, '0, 0, '0, '0, 0, 1, 64'hBBBB);
        vectors++; if (o_grant !== e || o_addr !== 64'h100 || o_if_rdata !== 64'hBBBB) begin
            miscompares++; $display("FAIL tie_if_next got %b addr=%h rdata=%h expected %b addr=100 rdata=bbbb", o_grant, o_addr, o_if_rdata, e); end
        e = predict(1, 1);
        run_txn(1, 64'h300, 1, 64'h400, 0, '0, '0, 0, 1, 64'hCCCC);
        vectors++; if (o_grant !== e || o_addr !== 64'h400) begin miscompares++; $display("FAIL tie2_grant got %b addr=%h expected %b addr=400", o_grant, o_addr, e); end
        e = predict(1, 0);
        run_txn(1, 64'h300, 0, '0, 0, '0, '0, 0, 1, 64'hDDDD);
        vectors++; if (o_grant !== e || o_bad !== 0) begin miscompares++; $display("FAIL tie_drain got %b bad=%0d expected %b bad=0", o_grant, o_bad, e); end
        idle_cycle();
    endtask

    task automatic test_ls_write();
        logic [1:0] e = predict(0, 1);
        run_txn(0, '0, 1, 64'h8000_1000, 1, 64'h1122_3344_5566_7788, 8'h0F, 3, 1, '0);
        vectors++; if (o_grant !== e) begin miscompares++; $display("FAIL wr_grant got %b expected %b", o_grant, e); end
        vectors++; if ({o_addr, o_wen, o_wdata, o_wmask} !== {64'h8000_1000, 1'b1, 64'h1122_3344_5566_7788, 8'h0F}) begin
            miscompares++; $display("FAIL wr_fields got %h/%b/%h/%h expected 80001000/1/1122334455667788/0f", o_addr, o_wen, o_wdata, o_wmask); end
        vectors++; if (o_stable !== 1'b1 || o_bad !== 0) begin miscompares++; $display("FAIL wr_hold got stable=%b bad=%0d expected 1/0", o_stable, o_bad); end
        vectors++; if ({o_if_rsp, o_ls_rsp} !== 2'b01) begin miscompares++; $display("FAIL wr_ack got if=%b ls=%b expected 0/1", o_if_rsp, o_ls_rsp); end
        idle_cycle();
        vectors++; if (o_after !== 3'b000) begin miscompares++; $display("FAIL wr_pulse got rsp/busy %b expected 000", o_after); end
    endtask

    task automatic test_backpressure();
        logic [1:0] e = predict(1, 0);
        run_txn(1, 64'h8000_0040, 0, '0, 0, '0, '0, 0, 11, 64'h5A5A_0000_1234_5678);
        vectors++; if (o_grant !== e || o_bad !== 0) begin miscompares++; $display("FAIL bp_wait got grant=%b bad=%0d expected %b/0", o_grant, o_bad, e); end
        vectors++; if (o_if_rsp !== 1'b1 || o_if_rdata !== 64'h5A5A_0000_1234_5678) begin
            miscompares++; $display("FAIL bp_rsp got %b/%h expected 1/5a5a000012345678", o_if_rsp, o_if_rdata); end
        idle_cycle();
    endtask

    task automatic test_spurious();
        logic [1:0] e;
        @(negedge clk);
        bus.mem_rsp_valid = 1;
        bus.mem_rdata = 64'hDEAD_BEEF;
        #1;
        vectors++; if ({bus.if_rsp_valid, bus.ls_rsp_valid} !== 2'b00 || {bus.if_rdata, bus.ls_rdata} !== '0) begin
            miscompares++; $display("FAIL spur_route got if=%b ls=%b expected 0/0 with zero data", bus.if_rsp_valid, bus.ls_rsp_valid); end
        model_err = 1;
        @(negedge clk);
        bus.mem_rsp_valid = 0;
        #1;
        vectors++; if (err !== model_err) begin miscompares++; $display("FAIL spur_err got %b expected %b", err, model_err); end
        e = predict(0, 1);
        run_txn(0, '0, 1, 64'h8000_2000, 0, '0, '0, 1, 2, 64'h77);
        vectors++; if (o_grant !== e || o_ls_rsp !== 1'b1 || o_ls_rdata !== 64'h77) begin
            miscompares++; $display("FAIL spur_txn got %b/%b/%h expected %b/1/77", o_grant, o_ls_rsp, o_ls_rdata, e); end
        idle_cycle();
        vectors++; if (err !== model_err) begin miscompares++; $display("FAIL spur_sticky got %b expected %b", err, model_err); end
    endtask

    task automatic test_reset_rsp();
        logic [1:0] e = predict(1, 0);
        @(negedge clk);
        bus.if_req_valid = 1; bus.if_addr = 64'h8000_0100;
        @(negedge clk);
        bus.if_req_valid = 0; bus.mem_req_ready = 1;
        @(negedge clk);
        bus.mem_req_ready = 0;
        #1;
        vectors++; if ({busy, bus.mem_req_valid} !== 2'b10) begin miscompares++; $display("FAIL rr_in_rsp got busy/req %b expected 10", {busy, bus.mem_req_valid}); end
        bus.mem_rsp_valid = 1;
        bus.mem_rdata = 64'h1234;
        rst_n = 0;
        model_last = 0;
        model_err = 0;
        #1;
        vectors++; if ({bus.if_req_ready, bus.ls_req_ready, bus.mem_req_valid, bus.if_rsp_valid, bus.ls_rsp_valid, busy, err} !== 7'b0 || {bus.if_rdata, bus.ls_rdata} !== '0) begin
            miscompares++; $display("FAIL rr_async got %b expected 0000000", {bus.if_req_ready, bus.ls_req_ready, bus.mem_req_valid, bus.if_rsp_valid, bus.ls_rsp_valid, busy, err}); end
        @(negedge clk);
        clear_inputs();
        rst_n = 1;
        e = predict(1, 0);
        run_txn(1, 64'h8000_0200, 0, '0, 0, '0, '0, 0, 1, 64'h4321);
        vectors++; if (o_grant !== e || o_if_rsp !== 1'b1 || o_if_rdata !== 64'h4321 || o_addr !== 64'h8000_0200) begin
            miscompares++; $display("FAIL rr_after got %b/%b/%h addr=%h expected %b/1/4321 addr=80000200", o_grant, o_if_rsp, o_if_rdata, o_addr, e); end
        idle_cycle();
    endtask

    // Back-to-back random traffic; a losing requester keeps its request until granted
    task automatic test_random();
        bit ip = 0, lp = 0, lw = 0;
        logic [AW-1:0] ia = '0, la = '0;
        logic [DW-1:0] ld = '0, rd;
        logic [MW-1:0] lm = '0;
        logic [1:0] e;
        for (int n = 0; n < 40; n++) begin
            if (!ip && $urandom_range(1) == 1) begin ip = 1; ia = {$urandom, $urandom}; end
            if (!lp && $urandom_range(1) == 1) begin
                lp = 1; la = {$urandom, $urandom}; lw = 1'($urandom); ld = {$urandom, $urandom}; lm = 8'($urandom);
            end
            if (!ip && !lp) begin ip = 1; ia = {$urandom, $urandom}; end
            e = predict(ip, lp);
            rd = {$urandom, $urandom};
            run_txn(ip, ia, lp, la, lw, ld, lm, $urandom_range(2), $urandom_range(3, 1), rd);
            vectors++; if (o_grant !== e || o_tries !== 1) begin
                miscompares++; $display("FAIL rnd%0d_grant got %b tries=%0d expected %b tries=1", n, o_grant, o_tries, e); end
            vectors++; if (e[1] ? ({o_addr, o_wen, o_wdata, o_wmask} !== {la, lw, ld, lm}) : ({o_addr, o_wen, o_wmask} !== {ia, 1'b0, 8'h00})) begin
                miscompares++; $display("FAIL rnd%0d_fields got %h/%b/%h/%h", n, o_addr, o_wen, o_wdata, o_wmask); end
            vectors++; if (o_stable !== 1'b1 || o_bad !== 0) begin
                miscompares++; $display("FAIL rnd%0d_hold got stable=%b bad=%0d expected 1/0", n, o_stable, o_bad); end
            vectors++; if ({o_ls_rsp, o_if_rsp} !== e || o_if_rdata !== (e[0] ? rd : '0) || o_ls_rdata !== (e[1] ? rd : '0)) begin
                miscompares++; $display("FAIL rnd%0d_rsp got ls/if=%b%b rdata=%h/%h expected %b with %h", n, o_ls_rsp, o_if_rsp, o_if_rdata, o_ls_rdata, e, rd); end
            if (e[0]) ip = 0;
            if (e[1]) lp = 0;
        end
        idle_cycle();
        vectors++; if (o_after !== 3'b000 || err !== model_err) begin
            miscompares++; $display("FAIL rnd_end got rsp/busy %b err=%b expected 000 err=%b", o_after, err, model_err); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_if_read();
        test_tie();
        test_ls_write();
        test_backpressure();
        test_spurious();
        test_reset_rsp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ysyx_22050078_mem_arbiter.md
# ysyx_22050078_mem_arbiter

Two-port memory arbiter that shares one memory port between the instruction-fetch unit (read-only) and the load/store unit (read/write). It replaces the separate per-unit memory paths so that the core can run against a single external memory/bus model with variable latency. It sits between IFU/LSU and the memory side, and supports one outstanding transaction at a time.

## Interface
- ADDR_WIDTH, 64, request address width
- DATA_WIDTH, 64, data width; the byte mask is DATA_WIDTH/8 bits
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset (from the rst_n_sync domain)
- if_req_valid  in  1  IFU read request
- if_req_ready  out  1  IFU request accepted this cycle
- if_addr  in  ADDR_WIDTH  IFU read address
- if_rsp_valid  out  1  IFU read data valid, one-cycle pulse
- if_rdata  out  DATA_WIDTH  IFU read data
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted this cycle
- ls_addr  in  ADDR_WIDTH  LSU address
- ls_wen  in  1  1 = write, 0 = read
- ls_wdata  in  DATA_WIDTH  LSU write data
- ls_wmask  in  DATA_WIDTH/8  LSU byte write mask
- ls_rsp_valid  out  1  LSU read data or write ack, one-cycle pulse
- ls_rdata  out  DATA_WIDTH  LSU read data
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts the request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  latched request fields
- mem_rsp_valid  in  1  memory response (read data or write ack)
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  state is not IDLE
- err  out  1  sticky flag for an unexpected mem_rsp_valid

## Operation
- States: IDLE, REQ, RSP. Registers: owner (0 = IF, 1 = LS), last_grant, latched request fields, err.
- IDLE: the arbiter grants when any request valid is high.
  - One request valid: that requester wins.
  - Both valid: round-robin. The winner is the requester that is not last_grant.
  - The winner's ready is asserted combinationally in the same cycle. The arbiter latches addr/wen/wdata/wmask (IF: wen = 0, wmask = 0), sets owner and last_grant, and moves to REQ.
- REQ: mem_req_valid = 1 with the latched fields held stable. When mem_req_ready = 1, the arbiter moves to RSP.
- RSP: the arbiter waits for mem_rsp_valid.
  - On mem_rsp_valid, the owner's rsp_valid = 1 and its rdata = mem_rdata (combinational pass-through). Next state is IDLE.
  - The non-owner's rsp_valid stays 0. Both rdata outputs are 0 when the corresponding rsp_valid is low.
- Ready outputs are 0 outside IDLE. Requesters hold valid and fields until ready.
- mem_rsp_valid in IDLE or REQ is ignored for routing and sets err, which stays set until reset.
- mem_rsp_valid and mem_req_ready both high in REQ: only the req handshake is taken, and err is set.

## Timing
- Reset values:
  - state = IDLE, owner = 0, last_grant = IF (so LS wins the first tie).
  - All latched fields = 0.
  - All valid/ready outputs, busy and err = 0.
- Reset mid-transaction: return to IDLE immediately. The in-flight request is dropped and no rsp pulse is issued.
- Latency:
  - Accept at cycle T; mem_req_valid from T+1.
  - With mem_req_ready at T+1 and mem_rsp_valid at T+2, rsp_valid is at T+2.
  - The next accept is possible at T+3. Minimum issue interval is 3 cycles.
- mem_req_valid never drops before mem_req_ready. Fields do not change while in REQ.

## Structure
- Shared defines header holds:
  - the state encoding (2-bit: IDLE = 0, REQ = 1, RSP = 2)
  - the owner encoding (OWN_IF = 0, OWN_LS = 1)
  - the mask width macro
- Optional sub-module ysyx_22050078_rr_arb2: 2-way round-robin grant (inputs req[1:0] and last; outputs one-hot grant). The FSM and request latch remain in the top module.

## Test plan
- IF-only read: if_req_valid = 1 with addr 0x80000000; mem ready at once; rsp 2 cycles later with 0x00100073 → if_rsp_valid pulses one cycle with if_rdata = 0x00100073, and ls_rsp_valid stays 0.
- Tie after reset: both valid → LS granted first (ls_req_ready = 1, if_req_ready = 0). After its response, IF is granted next. A further tie grants LS again.
- LSU write: addr 0x80001000, wdata 0x1122334455667788, wmask 0x0F; mem_req_ready delayed 3 cycles → mem fields are held stable throughout; ack gives ls_rsp_valid for one cycle.
- Backpressure and latency: mem_rsp_valid delayed 10 cycles → busy = 1 and both readies = 0 for the whole wait, with no rsp pulse before mem_rsp_valid.
- Spurious response: mem_rsp_valid pulsed in IDLE → no rsp_valid on either side, err = 1 and stays 1 through later traffic.
- Reset during RSP: rst_n low in RSP → all outputs 0 asynchronously. After release, a new IF request completes normally.
